// File: rtl/multi_channel_fmeasure.sv
// Multi-channel reciprocal frequency meter: counts clk cycles and wave edges across an edge-aligned gate.
// Define FMEAS_SCAN_EN to measure every channel in turn on one start instead of only ch_sel.
module multi_channel_fmeasure #(
  parameter int CH             = 4,
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 1000000,
  parameter int TIMEOUT_CYCLES = 4000000,
  localparam int SEL_W         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    wave,
  input  logic             start,
  input  logic [SEL_W-1:0] ch_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ca,
  output logic [CNT_W-1:0] cb,
  output logic [SEL_W-1:0] res_ch,
  output logic             ovf,
  output logic             tmo
);
  // state | meaning
  // IDLE  | waiting for start
  // ARM   | waiting for the opening edge of the active channel (timeout armed)
  // COUNT | gate open for GATE_CYCLES cycles, counting clk and edges
  // CLOSE | gate expired, counting until the closing edge (timeout armed)
  // DONE  | one cycle: publish result, then idle or next scan channel

  localparam int TMR_MAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GATE_LD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef FMEAS_SCAN_EN
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);
`else
  localparam logic [SEL_W:0]   CH_L    = (SEL_W+1)'(CH);
`endif

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_CLOSE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CH-1:0]    sync1, sync2, sync3, pulse_vec;
  logic             edge_act;
  logic [SEL_W-1:0] ch_act, ch_nxt;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             ovf_acc, tmo_acc;
  logic             arm_load, gate_load, close_load, tmr_dec, count_en, tmo_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= wave;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pulse_vec = sync2 & ~sync3;
  assign edge_act  = pulse_vec[ch_act];
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch_act;
    arm_load   = 1'b0;
    gate_load  = 1'b0;
    close_load = 1'b0;
    tmr_dec    = 1'b0;
    count_en   = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ARM;
          arm_load  = 1'b1;
`ifdef FMEAS_SCAN_EN
          ch_nxt    = '0;
`else
          ch_nxt    = ({1'b0, ch_sel} < CH_L) ? ch_sel : '0;
`endif
        end
      end
      S_ARM: begin
        if (edge_act) begin
          state_nxt = S_COUNT;
          gate_load = 1'b1;
        end else if (tmr == '0) begin
          state_nxt = S_DONE;
          tmo_set   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_COUNT: begin
        count_en = 1'b1;
        if (tmr == '0) begin
          // an edge on the last gate cycle closes the gate without a CLOSE phase
          state_nxt  = edge_act ? S_DONE : S_CLOSE;
          close_load = !edge_act;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_CLOSE: begin
        count_en = 1'b1;
        if (edge_act) begin
          state_nxt = S_DONE;
        end else if (tmr == '0) begin
          state_nxt = S_DONE;
          tmo_set   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
`ifdef FMEAS_SCAN_EN
        if (ch_act != LAST_CH) begin
          state_nxt = S_ARM;
          arm_load  = 1'b1;
          ch_nxt    = ch_act + 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ch_act  <= '0;
      tmr     <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      ovf_acc <= 1'b0;
      tmo_acc <= 1'b0;
    end else begin
      state  <= state_nxt;
      ch_act <= ch_nxt;
      if (arm_load) begin
        tmr     <= TMO_LD;
        cnt_a   <= '0;
        cnt_b   <= '0;
        ovf_acc <= 1'b0;
        tmo_acc <= 1'b0;
      end else if (gate_load) begin
        tmr <= GATE_LD;
      end else if (close_load) begin
        tmr <= TMO_LD;
      end else if (tmr_dec) begin
        tmr <= tmr - 1'b1;
      end
      if (count_en) begin
        if (cnt_a == CNT_MAX) ovf_acc <= 1'b1;
        else                  cnt_a   <= cnt_a + 1'b1;
        if (edge_act) begin
          if (cnt_b == CNT_MAX) ovf_acc <= 1'b1;
          else                  cnt_b   <= cnt_b + 1'b1;
        end
      end
      if (tmo_set) tmo_acc <= 1'b1;
    end
  end

  // a timed-out measurement reports empty counts regardless of what CLOSE accumulated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      ca     <= '0;
      cb     <= '0;
      res_ch <= '0;
      ovf    <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        ca     <= tmo_acc ? '0 : cnt_a;
        cb     <= tmo_acc ? '0 : cnt_b;
        res_ch <= ch_act;
        ovf    <= ovf_acc & ~tmo_acc;
        tmo    <= tmo_acc;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_fmeasure.sv
// Self-checking bench for multi_channel_fmeasure: result model from pulse timing plus directed literal checks.
`timescale 1ns/1ps
module tb_multi_channel_fmeasure;
  localparam int CH    = 4;
  localparam int SEL_W = 2;
  localparam int TMO   = 50;
  localparam int G_A   = 10;
  localparam int G_B   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] wave = '0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [SEL_W-1:0] sel_a = '0, sel_b = '0;
  logic busy_a, done_a, ovf_a, tmo_a, busy_b, done_b, ovf_b, tmo_b;
  logic [31:0] ca_a, cb_a;
  logic [3:0]  ca_b, cb_b;
  logic [SEL_W-1:0] rch_a, rch_b;

  always #5 clk = ~clk;

  multi_channel_fmeasure #(.CH(4), .CNT_W(32), .GATE_CYCLES(G_A), .TIMEOUT_CYCLES(TMO)) u_a (
    .clk(clk), .rst(rst), .wave(wave), .start(start_a), .ch_sel(sel_a),
    .busy(busy_a), .done(done_a), .ca(ca_a), .cb(cb_a), .res_ch(rch_a), .ovf(ovf_a), .tmo(tmo_a));

  multi_channel_fmeasure #(.CH(3), .CNT_W(4), .GATE_CYCLES(G_B), .TIMEOUT_CYCLES(TMO)) u_b (
    .clk(clk), .rst(rst), .wave(wave[2:0]), .start(start_b), .ch_sel(sel_b),
    .busy(busy_b), .done(done_b), .ca(ca_b), .cb(cb_b), .res_ch(rch_b), .ovf(ovf_b), .tmo(tmo_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // wave[c]: period per[c] clk cycles, first rise right after edge ph[c]; per 0 = held low
  int per[CH] = '{default: 0};
  int ph[CH]  = '{default: 0};

  function automatic bit wave_at(int c, int n);
    if (per[c] == 0 || n < ph[c]) return 1'b0;
    return ((n - ph[c]) % per[c]) < (per[c] / 2);
  endfunction

  // a raw rise after edge n is seen by the controller at edge n+3
  function automatic bit pulse_at(int c, int q);
    int n = q - 3;
    return per[c] != 0 && n >= ph[c] && ((n - ph[c]) % per[c]) == 0;
  endfunction

  always @(negedge clk) for (int c = 0; c < CH; c++) wave[c] = wave_at(c, cyc);

  typedef struct {
    int dcyc; longint ca; longint cb; int ch; bit ovf; bit tmo;
  } res_t;

  res_t   qa[$], qb[$];
  int     bfrom[2]  = '{0, 0};
  int     buntil[2] = '{-1, -1};
  longint h_ca[2] = '{0, 0}, h_cb[2] = '{0, 0};
  int     h_ch[2] = '{0, 0};
  bit     h_ovf[2] = '{0, 0}, h_tmo[2] = '{0, 0};
  int     ndone[2] = '{0, 0}, l_dc[2] = '{0, 0};
  longint l_ca[2] = '{0, 0}, l_cb[2] = '{0, 0};
  int     l_ch[2] = '{0, 0};
  bit     l_ovf[2] = '{0, 0}, l_tmo[2] = '{0, 0};
  int     dl_ch[$];
  longint dl_ca[$], dl_cb[$];
  int     npass = 0, ntot = 0;

  task automatic chk(input int i, input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s[inst %0d] cycle %0d: got %0d expected %0d", nm, i, cyc, act, exp);
  endtask

  // result of one channel measurement whose ARM phase starts right after edge st
  function automatic res_t measure(int i, int c, int st);
    res_t r;
    int g = (i == 0) ? G_A : G_B;
    longint mx = (i == 0) ? 64'hFFFF_FFFF : 64'd15;
    int q0 = -1, q1 = -1;
    longint a = 0, b = 0;
    r.ch = c; r.ovf = 0; r.tmo = 0; r.ca = 0; r.cb = 0; r.dcyc = 0;
    for (int q = st + 1; q <= st + TMO; q++) if (pulse_at(c, q)) begin q0 = q; break; end
    if (q0 < 0) begin r.tmo = 1; r.dcyc = st + TMO + 1; return r; end
    for (int q = q0 + 1; q <= q0 + g; q++) if (pulse_at(c, q)) b++;
    if (pulse_at(c, q0 + g)) begin
      a = g; r.dcyc = q0 + g + 1;
    end else begin
      for (int q = q0 + g + 1; q <= q0 + g + TMO; q++) if (pulse_at(c, q)) begin q1 = q; break; end
      if (q1 < 0) begin r.tmo = 1; r.dcyc = q0 + g + TMO + 1; return r; end
      a = q1 - q0; b++; r.dcyc = q1 + 1;
    end
    r.ovf = (a > mx) || (b > mx);
    r.ca  = (a > mx) ? mx : a;
    r.cb  = (b > mx) ? mx : b;
    return r;
  endfunction

  task automatic do_start(input int i, input int ch, output int s);
    res_t r;
    int st, first, last, nch;
    @(negedge clk);
    if (i == 0) begin start_a = 1'b1; sel_a = ch[SEL_W-1:0]; end
    else        begin start_b = 1'b1; sel_b = ch[SEL_W-1:0]; end
    s = cyc + 1;
    nch = (i == 0) ? 4 : 3;
    if (s > buntil[i] + 1) begin
`ifdef FMEAS_SCAN_EN
      first = 0; last = nch - 1;
`else
      first = (ch < nch) ? ch : 0; last = first;
`endif
      st = s; bfrom[i] = s;
      for (int c = first; c <= last; c++) begin
        r = measure(i, c, st);
        if (i == 0) qa.push_back(r); else qb.push_back(r);
        st = r.dcyc;
      end
      buntil[i] = st - 1;
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    while (cyc <= buntil[i] + 2) @(negedge clk);
  endtask

  task automatic cfg(input int p0, input int p1, input int p2, input int p3);
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    for (int c = 0; c < CH; c++) ph[c] = cyc + 3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cfg(0, 0, 0, 0);
    qa.delete(); qb.delete();
    for (int i = 0; i < 2; i++) begin
      bfrom[i] = 0; buntil[i] = -1; h_ca[i] = 0; h_cb[i] = 0; h_ch[i] = 0; h_ovf[i] = 0; h_tmo[i] = 0;
    end
    #1;
    chk(0, "rst_busy_now", busy_a, 0);
    chk(0, "rst_ca_now", ca_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    res_t r;
    bit ed, od, ob, oo, ot;
    longint oca, ocb;
    int och;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        od = done_a; ob = busy_a; oca = longint'(ca_a); ocb = longint'(cb_a); och = int'(rch_a); oo = ovf_a; ot = tmo_a;
      end else begin
        od = done_b; ob = busy_b; oca = longint'(ca_b); ocb = longint'(cb_b); och = int'(rch_b); oo = ovf_b; ot = tmo_b;
      end
      ed = 1'b0;
      if (i == 0 && qa.size() > 0 && qa[0].dcyc == cyc) begin r = qa.pop_front(); ed = 1'b1; end
      if (i == 1 && qb.size() > 0 && qb[0].dcyc == cyc) begin r = qb.pop_front(); ed = 1'b1; end
      if (ed) begin
        h_ca[i] = r.ca; h_cb[i] = r.cb; h_ch[i] = r.ch; h_ovf[i] = r.ovf; h_tmo[i] = r.tmo;
      end
      chk(i, "done", od, ed);
      chk(i, "busy", ob, (cyc >= bfrom[i] && cyc <= buntil[i]));
      chk(i, "ca", oca, h_ca[i]);
      chk(i, "cb", ocb, h_cb[i]);
      chk(i, "res_ch", och, h_ch[i]);
      chk(i, "ovf", oo, h_ovf[i]);
      chk(i, "tmo", ot, h_tmo[i]);
      if (od) begin
        ndone[i]++; l_dc[i] = cyc; l_ca[i] = oca; l_cb[i] = ocb; l_ch[i] = och; l_ovf[i] = oo; l_tmo[i] = ot;
        if (i == 0) begin dl_ch.push_back(och); dl_ca.push_back(oca); dl_cb.push_back(ocb); end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, nd, nd2, base;
    int sca[4] = '{12, 12, 16, 10};
    int scb[4] = '{3, 2, 2, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk(0, "reset_busy", busy_a, 0);
    chk(0, "reset_done", done_a, 0);
    chk(1, "reset_ca", ca_b, 0);
    chk(1, "reset_tmo", tmo_b, 0);

    // channel 1, period 4: gate overruns into CLOSE
    cfg(0, 4, 0, 0);
    repeat (5) @(negedge clk);
    nd = ndone[0];
    do_start(0, 1, s);
    wait_idle(0);
`ifndef FMEAS_SCAN_EN
    chk(0, "p4_ndone", ndone[0] - nd, 1);
    chk(0, "p4_ca", l_ca[0], 12);
    chk(0, "p4_cb", l_cb[0], 3);
    chk(0, "p4_res_ch", l_ch[0], 1);
    chk(0, "p4_ovf", l_ovf[0], 0);
    chk(0, "p4_tmo", l_tmo[0], 0);
`endif

    // period 5: closing edge falls on the last gate cycle
    cfg(0, 5, 0, 0);
    repeat (5) @(negedge clk);
    do_start(0, 1, s);
    wait_idle(0);
`ifndef FMEAS_SCAN_EN
    chk(0, "p5_ca", l_ca[0], 10);
    chk(0, "p5_cb", l_cb[0], 2);
`endif

    // reset in the middle of a measurement, then a clean rerun
    cfg(0, 4, 0, 0);
    repeat (5) @(negedge clk);
    nd = ndone[0];
    do_start(0, 1, s);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    chk(0, "rst_no_done", ndone[0] - nd, 0);
    cfg(0, 4, 0, 0);
    repeat (5) @(negedge clk);
    nd2 = ndone[0];
    do_start(0, 1, s);
    wait_idle(0);
`ifndef FMEAS_SCAN_EN
    chk(0, "after_rst_ndone", ndone[0] - nd2, 1);
    chk(0, "after_rst_ca", l_ca[0], 12);
    chk(0, "after_rst_cb", l_cb[0], 3);
`endif

    // selected wave held low: ARM timeout
    cfg(0, 0, 0, 0);
    repeat (5) @(negedge clk);
    do_start(0, 2, s);
    wait_idle(0);
`ifndef FMEAS_SCAN_EN
    chk(0, "tmo_latency_51_53", (l_dc[0] - s >= 51 && l_dc[0] - s <= 53), 1);
    chk(0, "tmo_flag", l_tmo[0], 1);
    chk(0, "tmo_ca", l_ca[0], 0);
    chk(0, "tmo_cb", l_cb[0], 0);
`endif

    // 4-bit counters with a 40-cycle gate; out-of-range select maps to channel 0; start while busy ignored
    cfg(4, 0, 0, 0);
    repeat (5) @(negedge clk);
    nd = ndone[1];
    do_start(1, 3, s);
    repeat (20) @(negedge clk);
    do_start(1, 1, s);
    wait_idle(1);
    repeat (5) @(negedge clk);
`ifndef FMEAS_SCAN_EN
    chk(1, "sat_ndone", ndone[1] - nd, 1);
    chk(1, "sat_ca", l_ca[1], 15);
    chk(1, "sat_cb", l_cb[1], 10);
    chk(1, "sat_ovf", l_ovf[1], 1);
    chk(1, "sat_res_ch", l_ch[1], 0);
`endif

`ifdef FMEAS_SCAN_EN
    // scan all channels with periods 4/6/8/10
    cfg(4, 6, 8, 10);
    repeat (5) @(negedge clk);
    nd = ndone[0];
    base = dl_ch.size();
    do_start(0, 2, s);
    wait_idle(0);
    chk(0, "scan_ndone", ndone[0] - nd, 4);
    chk(0, "scan_busy_end", busy_a, 0);
    if (dl_ch.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk(0, "scan_res_ch", dl_ch[base + k], k);
        chk(0, "scan_ca", dl_ca[base + k], sca[k]);
        chk(0, "scan_cb", dl_cb[base + k], scb[k]);
      end
    end
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
